lsu_ahb: RTL and testbench

LSU_AHB -- requirements
Module: lsu_ahb

---
 rtl/lsu_pkg.sv | 60 ++++++
 rtl/lsu_store_fifo.sv | 80 ++++++++
 rtl/lsu_ahb.sv | 185 ++++++++++++++++++
 tb/tb_lsu_ahb.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared AHB constants, RV32 funct3 encodings, bus FSM states and lane helpers
// for the load/store unit.
package lsu_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {StIdle, StAddr, StData} bus_state_e;

   function automatic logic [2:0] size_to_hsize(input logic [1:0] size);
      case (size)
         2'b00:   return HSIZE_BYTE;
         2'b01:   return HSIZE_HALF;
         default: return HSIZE_WORD;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return lane[0];
         default: return lane != 2'b00;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
      case (size)
         2'b00:   return {4{data[7:0]}};
         2'b01:   return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] rdata);
      logic [31:0] shifted;
      shifted = rdata >> {lane, 3'b000};
      case (f3)
         F3_B:    return {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   return {24'h0, shifted[7:0]};
         F3_H:    return {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   return {16'h0, shifted[15:0]};
         default: return rdata;
      endcase
   endfunction

endpackage

// File: rtl/lsu_store_fifo.sv
// In-order store buffer. An entry stays valid until its bus write retires, so the
// word-address match also covers the store currently on the bus.
module lsu_store_fifo #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned SB_DEPTH = 4,
   localparam int unsigned PTR_W   = $clog2(SB_DEPTH),
   localparam int unsigned CNT_W   = PTR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [31:0]       push_data,
   input  logic [2:0]        push_funct3,
   input  logic              pop,
   output logic [ADDR_W-1:0] head_addr,
   output logic [31:0]       head_data,
   output logic [2:0]        head_funct3,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count,
   input  logic [ADDR_W-3:0] match_addr,
   output logic              match
);

   logic [ADDR_W-1:0]   addr_q [SB_DEPTH];
   logic [31:0]         data_q [SB_DEPTH];
   logic [2:0]          f3_q   [SB_DEPTH];
   logic [SB_DEPTH-1:0] valid_q;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= push_addr;
         data_q[wr_ptr_q] <= push_data;
         f3_q[wr_ptr_q]   <= push_funct3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            valid_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q          <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            valid_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q          <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (!push && pop) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_comb begin
      match = 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i][ADDR_W-1:2] == match_addr)) begin
            match = 1'b1;
         end
      end
   end

   assign head_addr   = addr_q[rd_ptr_q];
   assign head_data   = data_q[rd_ptr_q];
   assign head_funct3 = f3_q[rd_ptr_q];
   assign count       = count_q;
   assign full        = (count_q == CNT_W'(SB_DEPTH));
   assign empty       = (count_q == '0);

endmodule

// File: rtl/lsu_ahb.sv
// Load/store unit with a buffered store path and a single-outstanding AHB-Lite
// master. Loads bypass buffered stores unless they hit the same word.
module lsu_ahb
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned SB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_load,
   input  logic              req_store,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [2:0]        req_funct3,
   input  logic [4:0]        req_rd,
   output logic              rsp_valid,
   output logic [4:0]        rsp_rd,
   output logic [31:0]       rsp_data,
   output logic              err_misaligned,
   output logic              err_bus,
   output logic              sb_empty,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [31:0]       HWDATA,
   input  logic [31:0]       HRDATA,
   input  logic              HREADY,
   input  logic [1:0]        HRESP
);

   localparam int unsigned CNT_W = $clog2(SB_DEPTH) + 1;

   bus_state_e        state_q, state_d;
   logic              load_pend_q;
   logic [ADDR_W-1:0] pend_addr_q, xfer_addr_q;
   logic [2:0]        pend_f3_q, xfer_f3_q;
   logic [4:0]        pend_rd_q, xfer_rd_q;
   logic              xfer_write_q;
   logic [31:0]       xfer_wdata_q;
   logic              rsp_valid_q, err_mis_q, err_bus_q;
   logic [4:0]        rsp_rd_q;
   logic [31:0]       rsp_data_q;

   logic              is_load, is_store, misaligned, load_busy, accept;
   logic              load_acc, store_push, bus_done, sb_pop, start;
   logic              sb_full, sb_fifo_empty, sb_match;
   logic [ADDR_W-1:0] head_addr;
   logic [31:0]       head_data;
   logic [2:0]        head_f3;
   logic [CNT_W-1:0]  sb_count;

   // A load wins over a store when both are flagged.
   assign is_load    = req_load;
   assign is_store   = req_store && !req_load;
   assign misaligned = is_misaligned(req_funct3[1:0], req_addr[1:0]);
   assign load_busy  = load_pend_q || ((state_q != StIdle) && !xfer_write_q);

   always_comb begin
      req_ready = 1'b1;
      if (is_load) begin
         req_ready = !load_busy && !sb_match;
      end else if (is_store) begin
         req_ready = !sb_full;
      end
   end

   assign accept     = req_valid && req_ready;
   assign load_acc   = accept && is_load && !misaligned;
   assign store_push = accept && is_store && !misaligned;
   assign bus_done   = (state_q == StData) && HREADY;
   assign sb_pop     = bus_done && xfer_write_q;

   lsu_store_fifo #(
      .ADDR_W   (ADDR_W),
      .SB_DEPTH (SB_DEPTH)
   ) u_store_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (store_push),
      .push_addr   (req_addr),
      .push_data   (req_wdata),
      .push_funct3 (req_funct3),
      .pop         (sb_pop),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .head_funct3 (head_f3),
      .full        (sb_full),
      .empty       (sb_fifo_empty),
      .count       (sb_count),
      .match_addr  (req_addr[ADDR_W-1:2]),
      .match       (sb_match)
   );

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load_acc || load_pend_q || !sb_fifo_empty) begin
               state_d = StAddr;
               start   = 1'b1;
            end
         end
         StAddr:  state_d = StData;
         StData:  if (HREADY) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         load_pend_q  <= 1'b0;
         pend_addr_q  <= '0;
         pend_f3_q    <= '0;
         pend_rd_q    <= '0;
         xfer_addr_q  <= '0;
         xfer_f3_q    <= '0;
         xfer_rd_q    <= '0;
         xfer_write_q <= 1'b0;
         xfer_wdata_q <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rd_q     <= '0;
         rsp_data_q   <= '0;
         err_mis_q    <= 1'b0;
         err_bus_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_mis_q   <= accept && (is_load || is_store) && misaligned;
         err_bus_q   <= bus_done && (HRESP == HRESP_ERROR);
         rsp_valid_q <= bus_done && !xfer_write_q;
         if (bus_done && !xfer_write_q) begin
            rsp_rd_q   <= xfer_rd_q;
            rsp_data_q <= (HRESP == HRESP_ERROR) ? 32'h0
                                                 : load_extend(xfer_f3_q, xfer_addr_q[1:0], HRDATA);
         end
         // A load arriving while the bus is busy parks until the FSM returns to idle.
         if (load_acc && (state_q != StIdle)) begin
            load_pend_q <= 1'b1;
            pend_addr_q <= req_addr;
            pend_f3_q   <= req_funct3;
            pend_rd_q   <= req_rd;
         end
         if (start) begin
            if (load_acc) begin
               xfer_addr_q  <= req_addr;
               xfer_f3_q    <= req_funct3;
               xfer_rd_q    <= req_rd;
               xfer_write_q <= 1'b0;
            end else if (load_pend_q) begin
               load_pend_q  <= 1'b0;
               xfer_addr_q  <= pend_addr_q;
               xfer_f3_q    <= pend_f3_q;
               xfer_rd_q    <= pend_rd_q;
               xfer_write_q <= 1'b0;
            end else begin
               xfer_addr_q  <= head_addr;
               xfer_f3_q    <= head_f3;
               xfer_write_q <= 1'b1;
               xfer_wdata_q <= store_lanes(head_f3[1:0], head_data);
            end
         end
      end
   end

   assign HTRANS = (state_q == StAddr) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR  = (state_q == StAddr) ? xfer_addr_q : '0;
   assign HWRITE = (state_q == StAddr) && xfer_write_q;
   assign HSIZE  = (state_q == StAddr) ? size_to_hsize(xfer_f3_q[1:0]) : HSIZE_WORD;
   assign HBURST = 3'b000;
   assign HWDATA = ((state_q == StData) && xfer_write_q) ? xfer_wdata_q : 32'h0;

   assign rsp_valid      = rsp_valid_q;
   assign rsp_rd         = rsp_rd_q;
   assign rsp_data       = rsp_data_q;
   assign err_misaligned = err_mis_q;
   assign err_bus        = err_bus_q;
   assign sb_empty       = (sb_count == '0) && !((state_q != StIdle) && xfer_write_q);

endmodule

// File: tb/tb_lsu_ahb.sv
// Self-checking bench for lsu_ahb: load responses and bus writes are predicted at
// issue time and matched against what the DUT produces.
module tb_lsu_ahb;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_load, req_store;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_funct3;
   logic [4:0]  req_rd;
   logic        rsp_valid;
   logic [4:0]  rsp_rd;
   logic [31:0] rsp_data;
   logic        err_misaligned, err_bus, sb_empty;
   logic [31:0] HADDR, HWDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE, HBURST;
   logic [31:0] hrdata;
   logic        hready;
   logic [1:0]  hresp;

   typedef struct {logic [4:0] rd; logic [31:0] data;} rsp_t;
   typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
   rsp_t rq[$];
   wr_t  wq[$];

   int n_vec = 0;
   int n_err = 0;
   bit chk_order = 0;
   bit          dph = 0;
   bit          dph_write = 0;
   logic [31:0] dph_addr = '0;

   always #5 clk = ~clk;

   lsu_ahb dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_load       (req_load),
      .req_store      (req_store),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_funct3     (req_funct3),
      .req_rd         (req_rd),
      .rsp_valid      (rsp_valid),
      .rsp_rd         (rsp_rd),
      .rsp_data       (rsp_data),
      .err_misaligned (err_misaligned),
      .err_bus        (err_bus),
      .sb_empty       (sb_empty),
      .HADDR          (HADDR),
      .HTRANS         (HTRANS),
      .HWRITE         (HWRITE),
      .HSIZE          (HSIZE),
      .HBURST         (HBURST),
      .HWDATA         (HWDATA),
      .HRDATA         (hrdata),
      .HREADY         (hready),
      .HRESP          (hresp)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] lane,
                                            input logic [31:0] w);
      logic [31:0] s;
      s = w >> (8 * lane);
      case (f3)
         3'b000:  return (s[7] ? 32'hFFFF_FF00 : 32'h0) | (s & 32'hFF);
         3'b100:  return s & 32'hFF;
         3'b001:  return (s[15] ? 32'hFFFF_0000 : 32'h0) | (s & 32'hFFFF);
         3'b101:  return s & 32'hFFFF;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   return (d & 32'hFF) * 32'h0101_0101;
         2'b01:   return (d & 32'hFFFF) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic bit exp_mis(input logic [2:0] f3, input logic [31:0] a);
      return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds the request until accepted; returns with time just past the accepting edge.
   task automatic issue(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input logic [4:0] rd,
                        input bit want_rsp, output int stall);
      stall      = 0;
      req_valid  = 1'b1;
      req_load   = ld;
      req_store  = st;
      req_addr   = addr;
      req_wdata  = wdata;
      req_funct3 = f3;
      req_rd     = rd;
      @(negedge clk);
      while (!req_ready && stall < 200) begin
         @(negedge clk);
         stall++;
      end
      if (!req_ready) begin
         $display("FAIL req_timeout: got ready=0 expected ready=1 addr %h", addr);
         n_err++;
      end
      if (ld && !exp_mis(f3, addr) && want_rsp) begin
         rq.push_back('{rd: rd, data: (hresp == 2'b01) ? 32'h0 : exp_load(f3, addr[1:0], hrdata)});
      end else if (st && !ld && !exp_mis(f3, addr)) begin
         wq.push_back('{addr: addr, data: exp_wdata(f3, wdata)});
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_load  = 1'b0;
      req_store = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((rq.size() != 0 || wq.size() != 0 || !sb_empty) && n < 100) begin
         tick();
         n++;
      end
      check("drain", rq.size() + wq.size(), 0);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         dph = 0;
      end else begin
         if (rsp_valid) begin
            if (rq.size() == 0) begin
               check("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
            end else begin
               rsp_t e;
               e = rq.pop_front();
               check("rsp_rd", {27'h0, rsp_rd}, {27'h0, e.rd});
               check("rsp_data", rsp_data, e.data);
            end
         end
         if (dph && hready) begin
            if (dph_write) begin
               if (wq.size() == 0) begin
                  check("wr_unexpected", dph_addr, 32'hFFFF_FFFF);
               end else begin
                  wr_t w;
                  w = wq.pop_front();
                  check("wr_addr", dph_addr, w.addr);
                  check("wr_data", HWDATA, w.data);
               end
            end
            dph = 0;
         end
         if (HTRANS == 2'b10) begin
            dph       = 1;
            dph_addr  = HADDR;
            dph_write = HWRITE;
            if (!HWRITE && chk_order) check("rd_after_wr", wq.size(), 0);
         end
      end
   end

   typedef struct {logic [2:0] f3; logic [31:0] addr; logic [31:0] word;} ld_vec_t;
   ld_vec_t lv[5] = '{
      '{f3: 3'b000, addr: 32'h103, word: 32'h8000_0000},
      '{f3: 3'b100, addr: 32'h103, word: 32'h8000_0000},
      '{f3: 3'b001, addr: 32'h102, word: 32'hF00D_1234},
      '{f3: 3'b101, addr: 32'h100, word: 32'h1234_8001},
      '{f3: 3'b000, addr: 32'h101, word: 32'h0000_7F00}
   };

   initial begin
      int st;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_load  = 1'b0;
      req_store = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_funct3 = '0;
      req_rd    = '0;
      hrdata    = '0;
      hready    = 1'b1;
      hresp     = 2'b00;
      tick();
      tick();
      check("rst_htrans", {30'h0, HTRANS}, 32'h0);
      check("rst_haddr", HADDR, 32'h0);
      check("rst_hwrite", {31'h0, HWRITE}, 32'h0);
      check("rst_hsize", {29'h0, HSIZE}, 32'h2);
      check("rst_hwdata", HWDATA, 32'h0);
      check("rst_hburst", {29'h0, HBURST}, 32'h0);
      check("rst_rsp", {26'h0, rsp_valid, rsp_rd}, 32'h0);
      check("rst_err", {30'h0, err_misaligned, err_bus}, 32'h0);
      check("rst_sb_empty", {31'h0, sb_empty}, 32'h1);
      check("rst_ready", {31'h0, req_ready}, 32'h1);
      reset = 1'b0;
      tick();

      // LW with nominal latency
      hrdata = 32'hDEAD_BEEF;
      issue(1, 0, 32'h100, 0, 3'b010, 5'd7, 1, st);
      check("lw_addr_htrans", {30'h0, HTRANS}, 32'h2);
      check("lw_haddr", HADDR, 32'h100);
      check("lw_hwrite_hsize", {28'h0, HWRITE, HSIZE}, 32'h2);
      tick();
      check("lw_data_htrans", {30'h0, HTRANS}, 32'h0);
      check("lw_rsp_early", {31'h0, rsp_valid}, 32'h0);
      tick();
      check("lw_rsp_t3", {31'h0, rsp_valid}, 32'h1);
      drain();

      foreach (lv[i]) begin
         hrdata = lv[i].word;
         issue(1, 0, lv[i].addr, 0, lv[i].f3, 5'(i + 1), 1, st);
         drain();
      end

      // Fill the buffer with the bus stalled; the fifth store must wait
      hready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue(0, 1, 32'h300 + 32'(4 * i), 32'h1111_0000 + 32'(i), 3'b010, 0, 0, st);
         check("sw_no_stall", st, 0);
      end
      check("sw_sb_busy", {31'h0, sb_empty}, 32'h0);
      fork
         issue(0, 1, 32'h310, 32'h5555_AAAA, 3'b010, 0, 0, st);
         begin
            repeat (6) tick();
            hready = 1'b1;
         end
      join
      check("sw5_stalled", {31'h0, st >= 5}, 32'h1);
      issue(0, 1, 32'h401, 32'h0000_00A5, 3'b000, 0, 0, st);
      issue(0, 1, 32'h402, 32'h9999_1234, 3'b001, 0, 0, st);
      drain();
      check("sw_sb_empty", {31'h0, sb_empty}, 32'h1);

      // Load to a buffered store's word waits for the write
      hready = 1'b0;
      hrdata = 32'h1122_3344;
      chk_order = 1;
      issue(0, 1, 32'h200, 32'hCAFE_F00D, 3'b010, 0, 0, st);
      fork
         issue(1, 0, 32'h200, 0, 3'b010, 5'd9, 1, st);
         begin
            repeat (4) tick();
            hready = 1'b1;
         end
      join
      check("raw_stalled", {31'h0, st >= 3}, 32'h1);
      drain();
      chk_order = 0;

      // Misaligned accesses
      issue(1, 0, 32'h101, 0, 3'b001, 5'd3, 1, st);
      check("lh_mis_err", {31'h0, err_misaligned}, 32'h1);
      check("lh_mis_htrans", {30'h0, HTRANS}, 32'h0);
      tick();
      check("lh_mis_pulse", {31'h0, err_misaligned}, 32'h0);
      check("lh_mis_htrans2", {30'h0, HTRANS}, 32'h0);
      issue(0, 1, 32'h202, 32'h1, 3'b010, 0, 0, st);
      check("sw_mis_err", {31'h0, err_misaligned}, 32'h1);
      check("sw_mis_sb", {31'h0, sb_empty}, 32'h1);
      drain();

      // Bus error on a load
      hresp = 2'b01;
      hrdata = 32'h7777_7777;
      issue(1, 0, 32'h500, 0, 3'b010, 5'd11, 1, st);
      tick();
      tick();
      check("berr_pulse", {30'h0, err_bus, rsp_valid}, 32'h3);
      hresp = 2'b00;
      drain();
      tick();
      check("berr_clear", {31'h0, err_bus}, 32'h0);

      // Reset during a stalled data phase
      hready = 1'b0;
      issue(1, 0, 32'h600, 0, 3'b010, 5'd12, 0, st);
      tick();
      reset = 1'b1;
      tick();
      check("rst_mid_htrans", {30'h0, HTRANS}, 32'h0);
      check("rst_mid_sb", {31'h0, sb_empty}, 32'h1);
      check("rst_mid_rsp", {30'h0, rsp_valid, err_bus}, 32'h0);
      reset = 1'b0;
      hready = 1'b1;
      repeat (5) tick();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
